// File: rtl/spi_flash_responder.sv
// SPI mode-3 target that behaves like a serial NOR flash: it decodes READ (0x03)
// and JEDEC ID (0x9F), fetches bytes from a synchronous-read memory and streams
// them out on MISO. SCK, MOSI and CS_N are oversampled in the clk domain.
//
// Handshake with the backing memory: o_mem_rd is a one-clk strobe qualifying
// o_mem_addr; i_mem_data is taken exactly one clk after the strobe. There is no
// back-pressure and the strobe is never high on two consecutive clks.
module spi_flash_responder #(
  parameter int          MEM_AW   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_mosi,
  input  logic              i_cs_n,
  output logic              o_miso,
  output logic              o_mem_rd,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_busy,
  output logic              o_bad_cmd,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_LOAD   = 3'd3,  // waiting for the first fetched byte
    ST_DATA   = 3'd4,
    ST_ID     = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_mosi_s1, r_mosi_s2;
  logic r_cs_s1, r_cs_s2;
  logic r_armed;  // set once synced cs_n has been seen high since reset

  logic [4:0]        r_cnt;
  logic [22:0]       r_rx_sr;
  logic [7:0]        r_tx_sr;
  logic [7:0]        r_next_byte;
  logic [2:0]        r_bcnt;
  logic              r_started;
  logic [1:0]        r_id_idx;
  logic [MEM_AW-1:0] r_addr;
  logic              r_miso;
  logic              r_mem_rd;
  logic [MEM_AW-1:0] r_mem_addr;
  logic              r_rd_d;
  logic              r_bad_cmd;

  logic              w_rise, w_fall, w_cs_hi;
  logic [23:0]       w_rx_word;
  logic              w_bad, w_addr_done, w_id_start, w_load_first;
  logic              w_shift_out, w_reload;
  logic [7:0]        w_next_src, w_out_byte;
  logic [MEM_AW-1:0] w_addr_inc;

  assign w_rise     = r_sck_s2 & ~r_sck_d;
  assign w_fall     = ~r_sck_s2 & r_sck_d;
  assign w_cs_hi    = r_cs_s2;
  assign w_rx_word  = {r_rx_sr, r_mosi_s2};
  assign w_addr_inc = r_addr + MEM_AW'(1);

  // Shifting out happens only on falls in DATA/ID; a byte boundary reloads
  // from the holding source once the first byte has started.
  assign w_shift_out = w_fall && !w_cs_hi && (r_state == ST_DATA || r_state == ST_ID);
  assign w_reload    = (r_bcnt == 3'd0) && r_started;
  assign w_out_byte  = w_reload ? w_next_src : r_tx_sr;

  // Next byte source: fetched memory byte in DATA, next ID byte (then 0xFF) in ID.
  always_comb begin
    w_next_src = 8'hFF;
    if (r_state == ST_DATA) begin
      w_next_src = r_next_byte;
    end else begin
      case (r_id_idx)
        2'd0:    w_next_src = JEDEC_ID[15:8];
        2'd1:    w_next_src = JEDEC_ID[7:0];
        default: w_next_src = 8'hFF;
      endcase
    end
  end

  // Input synchronizers and sck edge-detect flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck_s1  <= 1'b1;
      r_sck_s2  <= 1'b1;
      r_sck_d   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_sck_s1  <= i_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_cs_s1   <= i_cs_n;
      r_cs_s2   <= r_cs_s1;
      if (w_cs_hi) r_armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; cs_n high overrides everything, including sck edges.
  always_comb begin
    w_state_nxt  = r_state;
    w_bad        = 1'b0;
    w_addr_done  = 1'b0;
    w_id_start   = 1'b0;
    w_load_first = 1'b0;
    if (w_cs_hi) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (r_armed) w_state_nxt = ST_CMD;
        ST_CMD: begin
          if (w_rise && r_cnt == 5'd7) begin
            case (w_rx_word[7:0])
              8'h03: w_state_nxt = ST_ADDR;
              8'h9F: begin
                w_state_nxt = ST_ID;
                w_id_start  = 1'b1;
              end
              default: begin
                w_state_nxt = ST_IGNORE;
                w_bad       = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (w_rise && r_cnt == 5'd23) begin
            w_state_nxt = ST_LOAD;
            w_addr_done = 1'b1;
          end
        end
        ST_LOAD: begin
          if (r_rd_d) begin
            w_state_nxt  = ST_DATA;
            w_load_first = 1'b1;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath: shift-in, memory fetch, shift-out and the registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_next_byte <= '0;
      r_bcnt      <= '0;
      r_started   <= 1'b0;
      r_id_idx    <= '0;
      r_addr      <= '0;
      r_miso      <= 1'b1;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_rd_d      <= 1'b0;
      r_bad_cmd   <= 1'b0;
    end else begin
      r_rd_d    <= r_mem_rd;
      r_mem_rd  <= 1'b0;
      r_bad_cmd <= w_bad;
      if (w_cs_hi || r_state == ST_IDLE) begin
        r_cnt     <= '0;
        r_bcnt    <= '0;
        r_started <= 1'b0;
        r_id_idx  <= '0;
        r_miso    <= 1'b1;
      end else begin
        if (w_rise && (r_state == ST_CMD || r_state == ST_ADDR)) begin
          r_rx_sr <= w_rx_word[22:0];
          r_cnt   <= (r_state == ST_CMD && r_cnt == 5'd7) ? 5'd0 : r_cnt + 5'd1;
        end
        if (w_id_start) r_tx_sr <= JEDEC_ID[23:16];
        if (w_addr_done) begin
          r_addr     <= w_rx_word[MEM_AW-1:0];
          r_mem_rd   <= 1'b1;
          r_mem_addr <= w_rx_word[MEM_AW-1:0];
        end
        if (w_load_first) begin
          r_tx_sr    <= i_mem_data;
          r_addr     <= w_addr_inc;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= w_addr_inc;
        end
        if (r_state == ST_DATA && r_rd_d) r_next_byte <= i_mem_data;
        if (w_shift_out) begin
          r_miso    <= w_out_byte[7];
          r_tx_sr   <= {w_out_byte[6:0], 1'b1};
          r_bcnt    <= r_bcnt + 3'd1;
          r_started <= 1'b1;
          if (w_reload && r_state == ST_DATA) begin
            r_addr     <= w_addr_inc;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_addr_inc;
          end
          if (w_reload && r_state == ST_ID && r_id_idx != 2'd2) r_id_idx <= r_id_idx + 2'd1;
        end
      end
    end
  end

  assign o_miso      = r_miso;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_addr  = r_mem_addr;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_bad_cmd   = r_bad_cmd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: acts as the SPI controller, models the
// synchronous-read backing memory and logs every memory read strobe.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b1;
  logic        mosi = 1'b1;
  logic        cs_n = 1'b1;
  logic        miso;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        busy;
  logic        bad_cmd;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int bad_cnt = 0;
  int consec_rd = 0;
  logic rd_prev = 1'b0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [23:0] exp_rd_q[$];
  logic [23:0] rd_q[$];

  // clock / reset
  always #5 clk = ~clk;

  spi_flash_responder #(.MEM_AW(24), .JEDEC_ID(24'hEF4018)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sck      (sck),
    .i_mosi     (mosi),
    .i_cs_n     (cs_n),
    .o_miso     (miso),
    .o_mem_rd   (mem_rd),
    .o_mem_addr (mem_addr),
    .i_mem_data (mem_data),
    .o_busy     (busy),
    .o_bad_cmd  (bad_cmd),
    .o_dbg_state(dbg_state)
  );

  // Backing memory contents used by the directed tests.
  function automatic logic [7:0] mem_f(input logic [23:0] a);
    case (a)
      24'h100000: mem_f = 8'hA5;
      24'h100001: mem_f = 8'h3C;
      24'h100002: mem_f = 8'h0F;
      24'h000010: mem_f = 8'h77;
      24'hFFFFFF: mem_f = 8'hC3;
      24'h000000: mem_f = 8'h81;
      default:    mem_f = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Synchronous-read memory model plus read-strobe and bad_cmd monitors.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem_f(mem_addr);
    if (!rst && mem_rd) rd_q.push_back(mem_addr);
    if (mem_rd && rd_prev) consec_rd <= consec_rd + 1;
    rd_prev <= mem_rd;
    if (bad_cmd) bad_cnt <= bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_cycle(input logic b, output logic m);
    sck = 1'b0;
    mosi = b;
    wait_clk(5);
    m = miso;
    sck = 1'b1;
    wait_clk(5);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic m;
    for (int i = 7; i >= 0; i--) sck_cycle(b[i], m);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic m;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(1'b1, m);
      b = {b[6:0], m};
    end
  endtask

  task automatic cs_low;
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high;
    cs_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic start_read(input logic [23:0] a);
    cs_low();
    send_byte(8'h03);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic recv_n(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      recv_byte(b);
      rx_q.push_back(b);
    end
  endtask

  // scoreboard: drain expected byte and read-address queues against observed
  task automatic score(input string tag);
    int ne, nr;
    ne = exp_q.size();
    check({tag, " byte count"}, rx_q.size(), ne);
    for (int i = 0; i < ne; i++)
      check({tag, " byte"}, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, {24'h0, exp_q[i]});
    nr = exp_rd_q.size();
    check({tag, " rd count"}, rd_q.size(), nr);
    for (int i = 0; i < nr; i++)
      check({tag, " rd addr"}, (i < rd_q.size()) ? {8'h0, rd_q[i]} : 32'hDEAD, {8'h0, exp_rd_q[i]});
    exp_q.delete();
    rx_q.delete();
    exp_rd_q.delete();
    rd_q.delete();
  endtask

  initial begin
    logic m;
    // reset state
    wait_clk(3);
    check("rst miso", miso, 1'b1);
    check("rst mem_rd", mem_rd, 1'b0);
    check("rst mem_addr", mem_addr, 24'h0);
    check("rst busy", busy, 1'b0);
    check("rst bad_cmd", bad_cmd, 1'b0);
    rst = 1'b0;
    wait_clk(4);
    rd_q.delete();
    bad_cnt = 0;

    // read 3 bytes at 0x100000
    start_read(24'h100000);
    recv_n(3);
    cs_high();
    exp_q = '{8'hA5, 8'h3C, 8'h0F};
    exp_rd_q = '{24'h100000, 24'h100001, 24'h100002, 24'h100003};
    score("read100000");
    check("read bad_cmd", bad_cnt, 0);

    // JEDEC ID then 0xFF padding, no memory reads
    cs_low();
    send_byte(8'h9F);
    recv_n(5);
    cs_high();
    exp_q = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};
    score("jedec");
    check("jedec bad_cmd", bad_cnt, 0);

    // unsupported command
    cs_low();
    send_byte(8'h05);
    check("badcmd pulses", bad_cnt, 1);
    check("badcmd busy", busy, 1'b1);
    recv_n(2);
    exp_q = '{8'hFF, 8'hFF};
    cs_n = 1'b1;
    wait_clk(2);
    check("badcmd busy 2clk after cs rise", busy, 1'b1);
    wait_clk(1);
    check("badcmd busy 3clk after cs rise", busy, 1'b0);
    wait_clk(2);
    score("badcmd");
    check("badcmd pulses total", bad_cnt, 1);

    // abort after 12 address bits, then a clean read of 0x000010
    cs_low();
    send_byte(8'h03);
    send_byte(8'hFF);
    for (int i = 0; i < 4; i++) sck_cycle(1'b1, m);
    cs_high();
    check("abort busy", busy, 1'b0);
    start_read(24'h000010);
    recv_n(1);
    cs_high();
    exp_q = '{8'h77};
    exp_rd_q = '{24'h000010, 24'h000011};
    score("abort");

    // address wrap at the top of the 24-bit space
    start_read(24'hFFFFFF);
    recv_n(2);
    cs_high();
    exp_q = '{8'hC3, 8'h81};
    exp_rd_q = '{24'hFFFFFF, 24'h000000, 24'h000001};
    score("wrap");

    // reset pulse in the middle of byte 2
    start_read(24'h100000);
    recv_n(1);
    sck_cycle(1'b1, m);
    sck_cycle(1'b1, m);
    check("pre-rst miso low", miso, 1'b0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("midrst miso", miso, 1'b1);
    check("midrst mem_rd", mem_rd, 1'b0);
    check("midrst mem_addr", mem_addr, 24'h0);
    check("midrst busy", busy, 1'b0);
    check("midrst bad_cmd", bad_cmd, 1'b0);
    sck_cycle(1'b1, m);
    check("midrst stays idle", busy, 1'b0);
    check("midrst miso idle", m, 1'b1);
    exp_q = '{8'hA5};
    exp_rd_q = '{24'h100000, 24'h100001, 24'h100002};
    score("pre-rst");
    cs_high();
    start_read(24'h100001);
    recv_n(1);
    cs_high();
    exp_q = '{8'h3C};
    exp_rd_q = '{24'h100001, 24'h100002};
    score("post-rst");

    check("no back-to-back mem_rd", consec_rd, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
